// File: rtl/cpu_pkg.sv
// Shared CPU definitions: M-extension ALU op codes, the mul/div sequencer
// state encoding, and the default datapath width.
package cpu_pkg;

    localparam int WIDTH_DEF = 32;

    // Op codes shared with the aludec table
    localparam logic [3:0] ALU_MUL = 4'b0100;
    localparam logic [3:0] ALU_DIV = 4'b0101;

    // Sequencer state encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // True for the op codes the sequencer will accept
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIV);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference and
// set the quotient bit when it does not go negative.
module div_step
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    // Remainder is always below the divisor, so shifted < 2*divisor and the
    // difference fits in WIDTH+1 bits with a trustworthy sign bit.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;

    assign shifted  = {rem, quo[WIDTH-1]};
    assign diff     = shifted - {1'b0, divisor};
    assign fits     = ~diff[WIDTH];
    assign rem_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/DIV sequencer. Accepts one op in IDLE, iterates a
// shift-add multiplier or a restoring divider for WIDTH cycles while
// stalling the CPU, then presents the result with a one-cycle done pulse.
module muldiv_sequencer
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] count;

    // Multiplier datapath
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_next;

    // Divider datapath (magnitudes; sign re-applied at the end)
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic             q_neg;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             last_iter;
    logic             accept;

    // Two's-complement magnitude; the most negative value maps to itself,
    // which is also its correct unsigned magnitude.
    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;

    assign last_iter = (count == LAST);
    assign accept    = (state == S_IDLE) && start && is_muldiv(alucontrol);
    assign acc_next  = mplier[0] ? (acc + mcand) : acc;

    // Stall covers the accept cycle and every iteration, but not DONE,
    // so the CPU advances exactly when write-back captures the result.
    assign stall = accept || (state == S_MUL) || (state == S_DIV);
    assign done  = (state == S_DONE);

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // Sequencer state and iteration counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    count <= '0;
                    if (accept) begin
                        if (alucontrol == ALU_MUL)
                            state <= S_MUL;
                        else if (b == '0)
                            state <= S_DONE;
                        else
                            state <= S_DIV;
                    end
                end
                S_MUL, S_DIV: begin
                    count <= count + CNT_W'(1);
                    if (last_iter)
                        state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Multiplier registers: latch operands on accept, shift-add per cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (accept && alucontrol == ALU_MUL) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (state == S_MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    // Divider registers: latch magnitudes and quotient sign on accept,
    // one restoring step per cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            q_neg   <= 1'b0;
        end else if (accept && alucontrol == ALU_DIV) begin
            rem     <= '0;
            quo     <= a_mag;
            divisor <= b_mag;
            q_neg   <= a[WIDTH-1] ^ b[WIDTH-1];
        end else if (state == S_DIV) begin
            rem     <= rem_next;
            quo     <= quo_next;
        end
    end

    // Result register: loaded on the edge into DONE so it is valid with
    // the done pulse, then held until the next op completes or reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            result <= '0;
        end else if (accept && alucontrol == ALU_DIV && b == '0) begin
            result <= '1;
        end else if (state == S_MUL && last_iter) begin
            result <= acc_next;
        end else if (state == S_DIV && last_iter) begin
            result <= q_neg ? -quo_next : quo_next;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed + randomized bench for muldiv_sequencer against an arithmetic
// reference model (truncated product, signed quotient toward zero).
module tb_muldiv_sequencer;

    localparam int W = 32;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0101;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   alucontrol;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         stall;
    logic         done;
    logic [W-1:0] result;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .alucontrol (alucontrol),
        .a          (a),
        .b          (b),
        .stall      (stall),
        .done       (done),
        .result     (result)
    );

    // Reference: low W bits of the product; signed division in 64 bits so
    // the most-negative / -1 case wraps naturally; all ones for b == 0.
    function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        longint sx;
        longint sy;
        longint q;
        logic [W-1:0] p;
        if (op == OP_MUL) begin
            p = x * y;
            return p;
        end
        if (y == '0) return '1;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q  = sx / sy;
        return q[W-1:0];
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble operand inputs after accept, track stall and
    // latency until done, then confirm the pulse is one cycle and result holds.
    // inject_at > 0 pulses a MUL start at that iteration, which must be ignored.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int inject_at);
        logic [W-1:0] exp;
        int n;
        int lat_exp;
        bit stall_ok;
        exp     = model(op, x, y);
        lat_exp = (op == OP_DIV && y == '0) ? 1 : W + 1;
        @(negedge clock);
        alucontrol = op; a = x; b = y; start = 1'b1;
        #1;
        check({tag, " stall_on_accept"}, W'(stall), W'(1));
        @(negedge clock);
        start = 1'b0; a = $urandom; b = $urandom;
        n = 1;
        stall_ok = 1'b1;
        while (done !== 1'b1 && n <= W + 8) begin
            if (stall !== 1'b1) stall_ok = 1'b0;
            if (n == inject_at) begin
                start = 1'b1; alucontrol = OP_MUL;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            n++;
        end
        start = 1'b0;
        check({tag, " latency"}, W'(n), W'(lat_exp));
        check({tag, " stall_in_flight"}, W'(stall_ok), W'(1));
        check({tag, " stall_on_done"}, W'(stall), W'(0));
        check({tag, " result"}, result, exp);
        @(negedge clock);
        check({tag, " done_width"}, W'(done), W'(0));
        check({tag, " result_hold"}, result, exp);
    endtask

    initial begin
        logic [W-1:0] prev;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [3:0]   rop;
        bit           seen_done;

        reset = 1'b1; start = 1'b0; alucontrol = 4'b0000; a = '0; b = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset done", W'(done), W'(0));
        check("reset result", result, '0);
        check("reset stall", W'(stall), W'(0));

        // Basic signs and special cases
        run_op("mul 7*6", OP_MUL, 32'd7, 32'd6, 0);
        run_op("mul -3*5", OP_MUL, 32'hFFFF_FFFD, 32'd5, 0);
        run_op("div -20/3", OP_DIV, 32'hFFFF_FFEC, 32'd3, 0);
        run_op("div 20/-3", OP_DIV, 32'd20, 32'hFFFF_FFFD, 0);
        run_op("div -20/-3", OP_DIV, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 0);
        run_op("div 5/0", OP_DIV, 32'd5, 32'd0, 0);
        run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("constant 42", model(OP_MUL, 32'd7, 32'd6), 32'd42);

        // Illegal op: no stall, no done, result untouched
        prev = result;
        @(negedge clock);
        start = 1'b1; alucontrol = 4'b0010; a = 32'd9; b = 32'd9;
        #1;
        check("illegal stall", W'(stall), W'(0));
        seen_done = 1'b0;
        repeat (5) begin
            @(negedge clock);
            if (done === 1'b1 || stall !== 1'b0) seen_done = 1'b1;
        end
        start = 1'b0;
        check("illegal quiet", W'(seen_done), W'(0));
        check("illegal result", result, prev);

        // Start pulsed mid-DIV is ignored
        run_op("div inject", OP_DIV, 32'd1000, 32'd7, 5);

        // Reset in the middle of a MUL
        @(negedge clock);
        start = 1'b1; alucontrol = OP_MUL; a = 32'd9; b = 32'd9;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("midreset done", W'(done), W'(0));
        check("midreset result", result, '0);
        check("midreset stall", W'(stall), W'(0));
        run_op("mul 2*3", OP_MUL, 32'd2, 32'd3, 0);

        // Reset and start together: op must not be accepted
        @(negedge clock);
        reset = 1'b1; start = 1'b1; alucontrol = OP_MUL; a = 32'd4; b = 32'd4;
        @(negedge clock);
        reset = 1'b0; start = 1'b0;
        #1;
        check("rst+start stall", W'(stall), W'(0));
        seen_done = 1'b0;
        repeat (W + 4) begin
            @(negedge clock);
            if (done === 1'b1) seen_done = 1'b1;
        end
        check("rst+start no done", W'(seen_done), W'(0));

        // Randomized ops, with occasional zero divisor and edge operands
        for (int i = 0; i < 24; i++) begin
            rop = ($urandom_range(0, 1) == 0) ? OP_MUL : OP_DIV;
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = W'($urandom_range(1, 15));
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), rop, ra, rb, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
